// File: rtl/mem_rsp_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module   : mem_rsp_pkg                                                      |
// | Desc     : Shared FSM encodings and constants for mem_responder.            |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mem_rsp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int WORD_BYTES = 4;
   localparam int WAIT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_rsp_array.sv
// +-----------------------------------------------------------------------------+
// | Module   : mem_rsp_array                                                    |
// | Desc     : Single-port word RAM, byte-masked write, registered read, no rst.|
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_rsp_array
   import mem_rsp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [WORD_BYTES-1:0] be,
   input  logic [IDX_W-1:0]      idx,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Read data only moves on an explicit read, so it holds through a stalled response.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (be[b]) begin
               mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
      if (re) begin
         rdata_q <= mem_q[idx];
      end
   end

   assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// +-----------------------------------------------------------------------------+
// | Module   : mem_responder                                                    |
// | Desc     : Valid/ready word memory responder with programmable wait states. |
// |            Optional byte-enable port when MEM_RSP_BYTE_WRITE_EN is defined. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_responder
   import mem_rsp_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef MEM_RSP_BYTE_WRITE_EN
   input  logic [3:0]  req_be,
`endif
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = (WAIT_CYCLES == 0) ? '0
                                                 : WAIT_CNT_W'(WAIT_CYCLES - 1);
   localparam logic [29:0]           DEPTH_W30 = 30'(DEPTH_WORDS);

   state_e                state_q, state_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [31:0]           addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  write_q, write_d;
   logic [3:0]            be_q, be_d;
   logic                  err_q, err_d;
   logic                  rd_ok_q, rd_ok_d;

   logic                  commit;
   logic                  in_idle;
   logic [3:0]            req_be_w;
   logic [31:0]           cur_addr;
   logic [31:0]           cur_wdata;
   logic                  cur_write;
   logic [3:0]            cur_be;
   logic [29:0]           word_off;
   logic                  cur_err;
   logic                  mem_we;
   logic                  mem_re;
   logic [31:0]           mem_rdata;

`ifdef MEM_RSP_BYTE_WRITE_EN
   assign req_be_w = req_be;
`else
   assign req_be_w = 4'hF;
`endif

   // With zero wait states the commit happens on the accept edge, so the live
   // request is used instead of the (not yet loaded) latched copy.
   assign in_idle   = (state_q == ST_IDLE);
   assign cur_addr  = in_idle ? req_addr  : addr_q;
   assign cur_wdata = in_idle ? req_wdata : wdata_q;
   assign cur_write = in_idle ? req_write : write_q;
   assign cur_be    = in_idle ? req_be_w  : be_q;

   assign word_off = 30'((cur_addr - BASE_ADDR) >> 2);
   assign cur_err  = (cur_addr[1:0] != 2'b00) || (word_off >= DEPTH_W30)
                     || (cur_write && (cur_be == 4'b0000));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_d    = write_q;
      be_d       = be_q;
      err_d      = err_q;
      rd_ok_d    = rd_ok_q;
      commit     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               write_d    = req_write;
               be_d       = req_be_w;
               wait_cnt_d = '0;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (commit) begin
         err_d   = cur_err;
         rd_ok_d = !cur_write && !cur_err;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         be_q       <= '0;
         err_q      <= 1'b0;
         rd_ok_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         write_q    <= write_d;
         be_q       <= be_d;
         err_q      <= err_d;
         rd_ok_q    <= rd_ok_d;
      end
   end

   assign mem_we = commit && cur_write && !cur_err;
   assign mem_re = commit && !cur_write && !cur_err;

   mem_rsp_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .be    (cur_be),
      .idx   (word_off[IDX_W-1:0]),
      .wdata (cur_wdata),
      .rdata (mem_rdata)
   );

   assign req_ready = in_idle;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = (rsp_valid && rd_ok_q) ? mem_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_mem_responder                                                 |
// | Desc     : Self-checking bench for mem_responder with a word-array model.   |
// |            Exercises byte enables when MEM_RSP_BYTE_WRITE_EN is defined.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_responder;

   localparam int          DEPTH = 1024;
   localparam int          WAITC = 2;
   localparam logic [31:0] BASE  = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = 4'hF;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] model_mem [DEPTH];
   bit          known [DEPTH];

   always #5 clk = ~clk;

   mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_CYCLES (WAITC),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
`ifdef MEM_RSP_BYTE_WRITE_EN
      .req_be    (req_be),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: error if misaligned, outside [BASE, BASE+4*DEPTH-1], or an empty byte mask store.
   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int hold);
      longint unsigned a, lo, hi;
      bit              exp_err, chk_rd;
      logic [31:0]     exp_rd;
      int              idx, n;
      a  = addr;
      lo = BASE;
      hi = longint'(BASE) + 4 * DEPTH - 1;
      exp_err = (addr[1:0] != 2'b00) || (a < lo) || (a > hi);
`ifdef MEM_RSP_BYTE_WRITE_EN
      if (wr && be == 4'b0000) exp_err = 1'b1;
`else
      be = 4'hF;
`endif
      idx    = exp_err ? 0 : int'((a - lo) / 4);
      exp_rd = 32'h0;
      chk_rd = 1'b1;
      if (!wr && !exp_err) begin
         if (known[idx]) exp_rd = model_mem[idx];
         else chk_rd = 1'b0;
      end
      if (wr && !exp_err && (known[idx] || be == 4'hF)) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
         known[idx] = 1'b1;
      end

      check("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      n = 0;
      while (!rsp_valid && n < 40) begin
         check("req_ready_wait", req_ready, 1'b0);
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, WAITC);
      for (int h = 0; h <= hold; h++) begin
         check("rsp_valid", rsp_valid, 1'b1);
         check("req_ready_resp", req_ready, 1'b0);
         check("rsp_err", rsp_err, exp_err);
         if (chk_rd) check("rsp_rdata", rsp_rdata, exp_rd);
         if (h < hold) begin
            @(posedge clk); #1;
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_valid_done", rsp_valid, 1'b0);
      check("req_ready_done", req_ready, 1'b1);
   endtask

   initial begin
      logic [31:0] a;
      int          sel, wi;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", rsp_err, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed scenarios
      do_txn(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 0);
      do_txn(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 4'hF, 0);
      do_txn(1'b0, 32'h0000_0080, 32'h0, 4'hF, 0);
      check("load_0x80_literal", model_mem[32], 32'hDEAD_BEEF);
      do_txn(1'b0, 32'h0000_0082, 32'h0, 4'hF, 0);
      do_txn(1'b0, 32'h0000_0080, 32'h0, 4'hF, 0);
      do_txn(1'b1, BASE + 4 * DEPTH, 32'h5555_AAAA, 4'hF, 1);
      do_txn(1'b0, 32'h0000_0000, 32'h0, 4'hF, 0);
      do_txn(1'b0, 32'h0000_0080, 32'h0, 4'hF, 5);

      // Reset while a store sits in WAIT
      do_txn(1'b1, 32'h0000_0084, 32'hCAFE_F00D, 4'hF, 0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0084;
      req_wdata = 32'h1234_5678;
      req_be    = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_req_ready", req_ready, 1'b1);
      check("midrst_rsp_valid", rsp_valid, 1'b0);
      check("midrst_rsp_rdata", rsp_rdata, 32'h0);
      check("midrst_rsp_err", rsp_err, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_txn(1'b0, 32'h0000_0084, 32'h0, 4'hF, 0);

`ifdef MEM_RSP_BYTE_WRITE_EN
      do_txn(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 4'hF, 0);
      do_txn(1'b1, 32'h0000_0080, 32'h0000_00AA, 4'b0001, 0);
      do_txn(1'b0, 32'h0000_0080, 32'h0, 4'hF, 0);
      check("be_merge_literal", model_mem[32], 32'hDEAD_BEAA);
      do_txn(1'b1, 32'h0000_0080, 32'h1111_1111, 4'b0000, 0);
      do_txn(1'b0, 32'h0000_0080, 32'h0, 4'hF, 0);
`endif

      // Prefill a set of words near both ends of the window
      for (int i = 0; i < 8; i++) begin
         do_txn(1'b1, BASE + 4 * i, $urandom, 4'hF, 0);
         do_txn(1'b1, BASE + 4 * (DEPTH - 1 - i), $urandom, 4'hF, 0);
      end

      for (int t = 0; t < 60; t++) begin
         wi  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : DEPTH - 1 - $urandom_range(0, 7);
         sel = $urandom_range(0, 9);
         case (sel)
            6:       a = BASE + 4 * wi + $urandom_range(1, 3);
            7:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
            8:       a = 32'hFFFF_FFFC;
            default: a = BASE + 4 * wi;
         endcase
         do_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
